memory_arbiter: RTL and testbench

Arbiter that shares the single-ported SOPC memory between the CPU instruction-fetch port and the load/store (data) port. It sits between `cpu` and the memory model inside `sopc`. It grants one requester at a time, with data priority and fetch anti-starvation. It holds the memory handshake until the memory acknowledges or times out, and it gives the pipeline a stall indication while any request is outstanding.

---
 rtl/memory_arbiter_pkg.sv | 18 +
 rtl/memory_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// arbiter_defines: shared types and constants for the fetch/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arbiter_defines;

    // Arbiter FSM encoding; the value 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between instruction fetch and load/store.
// Latency: grant one cycle after a request is sampled in IDLE; minimum access 2 cycles plus one IDLE bubble.
// Backpressure: requests are held until their ready; stall_request covers every outstanding request.
// Ports: clock/reset; fetch_* read-only requester; data_* load/store requester;
//        memory_* registered memory handshake; bus_error timeout pulse; stall_request to the pipeline.
module memory_arbiter
    import arbiter_defines::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int STARVE_LIMIT  = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fetch_request,
    input  logic [ADDRESS_WIDTH-1:0]  fetch_address,
    output logic [DATA_WIDTH-1:0]     fetch_data,
    output logic                      fetch_ready,
    input  logic                      data_request,
    input  logic                      data_write,
    input  logic [DATA_WIDTH/8-1:0]   data_select,
    input  logic [ADDRESS_WIDTH-1:0]  data_address,
    input  logic [DATA_WIDTH-1:0]     data_write_data,
    output logic [DATA_WIDTH-1:0]     data_read_data,
    output logic                      data_ready,
    output logic                      memory_enable,
    output logic                      memory_write,
    output logic [DATA_WIDTH/8-1:0]   memory_select,
    output logic [ADDRESS_WIDTH-1:0]  memory_address,
    output logic [DATA_WIDTH-1:0]     memory_write_data,
    input  logic [DATA_WIDTH-1:0]     memory_read_data,
    input  logic                      memory_ready,
    output logic                      bus_error,
    output logic                      stall_request
);

    localparam logic [3:0]            STARVE_MAX    = 4'(STARVE_LIMIT);
    localparam logic [7:0]            TIMEOUT_COUNT = 8'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA     = DATA_WIDTH'(ZERO_WORD);

    state_t     state;
    logic [3:0] starve_count;
    logic [7:0] wait_count;

    logic busy;
    logic timed_out;
    logic finish;
    logic fetch_wins;
    logic data_wins;

    assign busy      = (state == FETCH) || (state == DATA);
    // A real memory_ready on the timeout cycle still counts as a normal completion.
    assign timed_out = busy && !memory_ready && (wait_count == TIMEOUT_COUNT);
    assign finish    = busy && (memory_ready || timed_out);

    assign fetch_ready    = (state == FETCH) && finish;
    assign data_ready     = (state == DATA) && finish;
    // Read data is forced to zero on an aborted access so a timeout never leaks stale bus contents.
    assign fetch_data     = ((state == FETCH) && memory_ready) ? memory_read_data : ZERO_DATA;
    assign data_read_data = ((state == DATA) && memory_ready) ? memory_read_data : ZERO_DATA;
    assign bus_error      = timed_out;
    assign stall_request  = (fetch_request && !fetch_ready) || (data_request && !data_ready);

    // Data has priority unless fetch has already been passed over STARVE_LIMIT times.
    assign fetch_wins = fetch_request && (!data_request || (starve_count == STARVE_MAX));
    assign data_wins  = data_request && !fetch_wins;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            starve_count      <= '0;
            wait_count        <= '0;
            memory_enable     <= 1'b0;
            memory_write      <= 1'b0;
            memory_select     <= '0;
            memory_address    <= '0;
            memory_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_count <= '0;
                    if (fetch_wins) begin
                        state             <= FETCH;
                        starve_count      <= '0;
                        memory_enable     <= 1'b1;
                        memory_write      <= 1'b0;
                        memory_select     <= '1;
                        memory_address    <= fetch_address;
                        memory_write_data <= '0;
                    end else if (data_wins) begin
                        state             <= DATA;
                        if (fetch_request && (starve_count != STARVE_MAX)) begin
                            starve_count <= starve_count + 4'd1;
                        end
                        memory_enable     <= 1'b1;
                        memory_write      <= data_write;
                        memory_select     <= data_select;
                        memory_address    <= data_address;
                        memory_write_data <= data_write_data;
                    end
                end
                FETCH, DATA: begin
                    // Always return through IDLE so a still-held request is never granted twice.
                    if (finish) begin
                        state             <= IDLE;
                        memory_enable     <= 1'b0;
                        memory_write      <= 1'b0;
                        memory_select     <= '0;
                        memory_address    <= '0;
                        memory_write_data <= '0;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    memory_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: self-checking bench for memory_arbiter (STARVE_LIMIT 4, TIMEOUT 8).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: requesters hold their request until ready, then drop or replace it.
module tb_memory_arbiter;

    localparam int LIMIT       = 4;
    localparam int TMO         = 8;
    localparam int RAND_CYCLES = 3000;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        data_request;
    logic        data_write;
    logic [3:0]  data_select;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;
    logic        data_ready;
    logic        memory_enable;
    logic        memory_write;
    logic [3:0]  memory_select;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        memory_ready;
    logic        bus_error;
    logic        stall_request;

    memory_arbiter #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(LIMIT),
        .TIMEOUT(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fetch_request(fetch_request),
        .fetch_address(fetch_address),
        .fetch_data(fetch_data),
        .fetch_ready(fetch_ready),
        .data_request(data_request),
        .data_write(data_write),
        .data_select(data_select),
        .data_address(data_address),
        .data_write_data(data_write_data),
        .data_read_data(data_read_data),
        .data_ready(data_ready),
        .memory_enable(memory_enable),
        .memory_write(memory_write),
        .memory_select(memory_select),
        .memory_address(memory_address),
        .memory_write_data(memory_write_data),
        .memory_read_data(memory_read_data),
        .memory_ready(memory_ready),
        .bus_error(bus_error),
        .stall_request(stall_request)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_request    = 1'b0;
        fetch_address    = 32'h0;
        data_request     = 1'b0;
        data_write       = 1'b0;
        data_select      = 4'h0;
        data_address     = 32'h0;
        data_write_data  = 32'h0;
        memory_read_data = 32'h0;
        memory_ready     = 1'b0;
    endtask

    // One isolated access from IDLE: requests, expected winner and the fields it must put on the bus.
    typedef struct {
        logic        fr;
        logic        dr;
        logic        dw;
        logic [3:0]  ds;
        logic [31:0] fa;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] rd;
        int          lat;
        int          who;
        logic        ewrite;
        logic [3:0]  esel;
        logic [31:0] eaddr;
        logic [31:0] ewd;
    } vec_t;

    vec_t vecs [6];
    vec_t v;
    logic fin;
    logic exp_stall;

    int   n_data;
    bit   seen_fetch;
    bit   late_data;
    int   en;
    bit   got;
    bit   early_err;
    int   pulses;
    bit   stall_ok;

    // Behavioural model state for the random phase.
    bit          f_on, d_on, d_write;
    logic [31:0] f_addr, d_addr, d_wd;
    logic [3:0]  d_sel;
    int          m_owner;     // 0 none, 1 fetch, 2 data
    int          m_cycles;    // 1-based enabled cycle within the current access
    int          m_passed;    // data grants made while fetch was left waiting
    bit          m_stuck;
    logic        m_write;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wd;
    bit          done, exp_fr, exp_dr, exp_err;
    logic [31:0] exp_fd, exp_dd;

    initial begin
        vecs[0] = '{fr:1'b1, dr:1'b0, dw:1'b0, ds:4'h0, fa:32'h40, da:32'h0, dwd:32'h0, rd:32'h11112222,
                    lat:1, who:1, ewrite:1'b0, esel:4'hf, eaddr:32'h40, ewd:32'h0};
        vecs[1] = '{fr:1'b0, dr:1'b1, dw:1'b0, ds:4'hf, fa:32'h0, da:32'h80, dwd:32'h0, rd:32'hCAFEF00D,
                    lat:2, who:2, ewrite:1'b0, esel:4'hf, eaddr:32'h80, ewd:32'h0};
        vecs[2] = '{fr:1'b0, dr:1'b1, dw:1'b1, ds:4'b0010, fa:32'h0, da:32'h204, dwd:32'h0000AB00, rd:32'h0,
                    lat:4, who:2, ewrite:1'b1, esel:4'b0010, eaddr:32'h204, ewd:32'h0000AB00};
        vecs[3] = '{fr:1'b1, dr:1'b1, dw:1'b1, ds:4'hf, fa:32'h44, da:32'h108, dwd:32'h5A5A5A5A, rd:32'h0,
                    lat:1, who:2, ewrite:1'b1, esel:4'hf, eaddr:32'h108, ewd:32'h5A5A5A5A};
        vecs[4] = '{fr:1'b1, dr:1'b1, dw:1'b0, ds:4'b1100, fa:32'h48, da:32'h10C, dwd:32'h0, rd:32'h87654321,
                    lat:2, who:2, ewrite:1'b0, esel:4'b1100, eaddr:32'h10C, ewd:32'h0};
        vecs[5] = '{fr:1'b1, dr:1'b0, dw:1'b0, ds:4'h0, fa:32'h0, da:32'h0, dwd:32'h0, rd:32'h0BADC0DE,
                    lat:3, who:1, ewrite:1'b0, esel:4'hf, eaddr:32'h0, ewd:32'h0};

        // Reset state
        reset = 1'b1;
        idle_inputs();
        #1;
        check("reset_state",
              128'({memory_enable, memory_write, memory_select, memory_address, memory_write_data,
                    bus_error, stall_request, fetch_ready, data_ready}), 128'(0));
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Table-driven isolated accesses
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            fetch_request   = v.fr;
            fetch_address   = v.fa;
            data_request    = v.dr;
            data_write      = v.dw;
            data_select     = v.ds;
            data_address    = v.da;
            data_write_data = v.dwd;
            memory_ready    = 1'b0;
            #4;
            check($sformatf("vec%0d_request", i), 128'({memory_enable, stall_request}), 128'({1'b0, v.fr | v.dr}));
            next_cycle();
            for (int c = 1; c <= v.lat; c++) begin
                memory_ready     = (c == v.lat);
                memory_read_data = v.rd;
                #4;
                fin = (c == v.lat);
                exp_stall = (v.fr && !(fin && v.who == 1)) || (v.dr && !(fin && v.who == 2));
                check($sformatf("vec%0d_fields_c%0d", i, c),
                      128'({memory_enable, memory_write, memory_select, memory_address}),
                      128'({1'b1, v.ewrite, v.esel, v.eaddr}));
                if (v.who == 2)
                    check($sformatf("vec%0d_wdata_c%0d", i, c), 128'(memory_write_data), 128'(v.ewd));
                check($sformatf("vec%0d_ready_c%0d", i, c),
                      128'({fetch_ready, data_ready, fetch_data, data_read_data, bus_error, stall_request}),
                      128'({fin && v.who == 1, fin && v.who == 2,
                            (fin && v.who == 1) ? v.rd : 32'h0, (fin && v.who == 2) ? v.rd : 32'h0,
                            1'b0, exp_stall}));
                next_cycle();
            end
            idle_inputs();
            #4;
            check($sformatf("vec%0d_back_idle", i), 128'(memory_enable), 128'(0));
            next_cycle();
        end

        // Fetch only: ready on the 2nd enabled cycle, stall high before it
        fetch_request = 1'b1;
        fetch_address = 32'h10;
        pulses   = 0;
        stall_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            memory_ready     = (c == 2);
            memory_read_data = (c == 2) ? 32'h34010005 : 32'hFFFFFFFF;
            #4;
            if (c < 2 && !stall_request) stall_ok = 1'b0;
            if (fetch_ready) begin
                pulses++;
                check("fetch_only_data", 128'({c[1:0], fetch_data}), 128'({2'd2, 32'h34010005}));
            end
            next_cycle();
            if (c == 2) fetch_request = 1'b0;
        end
        check("fetch_only_pulses", 128'(pulses), 128'(1));
        check("fetch_only_stall", 128'(stall_ok), 128'(1));
        idle_inputs();

        // Simultaneous requests: data first, one IDLE bubble, then fetch
        fetch_request   = 1'b1;
        fetch_address   = 32'h20;
        data_request    = 1'b1;
        data_write      = 1'b1;
        data_select     = 4'hf;
        data_address    = 32'h100;
        data_write_data = 32'hDEADBEEF;
        next_cycle();
        memory_ready = 1'b1;
        #4;
        check("simul_data_grant",
              128'({memory_enable, memory_write, memory_select, memory_address, memory_write_data, data_ready, fetch_ready}),
              128'({1'b1, 1'b1, 4'hf, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0}));
        next_cycle();
        data_request = 1'b0;
        memory_ready = 1'b0;
        #4;
        check("simul_bubble", 128'({memory_enable, stall_request}), 128'({1'b0, 1'b1}));
        next_cycle();
        memory_ready = 1'b1;
        #4;
        check("simul_fetch_grant",
              128'({memory_enable, memory_write, memory_select, memory_address, fetch_ready}),
              128'({1'b1, 1'b0, 4'hf, 32'h20, 1'b1}));
        next_cycle();
        idle_inputs();
        next_cycle();

        // Starvation: both held continuously
        fetch_request = 1'b1;
        fetch_address = 32'h400;
        data_request  = 1'b1;
        data_write    = 1'b0;
        data_select   = 4'hf;
        data_address  = 32'h500;
        n_data     = 0;
        seen_fetch = 1'b0;
        late_data  = 1'b0;
        for (int c = 0; c < 60 && !seen_fetch; c++) begin
            memory_ready = memory_enable;
            #4;
            if (data_ready) n_data++;
            if (fetch_ready) seen_fetch = 1'b1;
            next_cycle();
        end
        check("starve_data_grants", 128'(n_data), 128'(LIMIT));
        check("starve_fetch_grant", 128'(seen_fetch), 128'(1));
        idle_inputs();
        #4;
        check("starve_count_clear", 128'(dut.starve_count), 128'(0));
        next_cycle();
        // After clearing, data must again win over a waiting fetch
        fetch_request = 1'b1;
        data_request  = 1'b1;
        data_address  = 32'h504;
        next_cycle();
        memory_ready = 1'b1;
        #4;
        check("starve_data_again", 128'({data_ready, fetch_ready, memory_address}), 128'({1'b1, 1'b0, 32'h504}));
        for (int c = 0; c < 20 && !late_data; c++) begin
            next_cycle();
            data_request = 1'b0;
            memory_ready = memory_enable;
            #4;
            if (fetch_ready) late_data = 1'b1;
        end
        check("starve_fetch_served", 128'(late_data), 128'(1));
        next_cycle();
        idle_inputs();
        next_cycle();

        // Timeout: memory never answers
        data_request     = 1'b1;
        data_write       = 1'b0;
        data_select      = 4'hf;
        data_address     = 32'h300;
        memory_read_data = 32'hFFFFFFFF;
        en        = 0;
        got       = 1'b0;
        early_err = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            #4;
            if (memory_enable) en++;
            if (data_ready) begin
                got = 1'b1;
                check("timeout_cycle", 128'(en), 128'(TMO + 1));
                check("timeout_err_rdata", 128'({bus_error, data_read_data}), 128'({1'b1, 32'h0}));
            end else if (bus_error) begin
                early_err = 1'b1;
            end
            next_cycle();
        end
        check("timeout_seen", 128'(got), 128'(1));
        check("timeout_no_early_err", 128'(early_err), 128'(0));
        idle_inputs();
        #4;
        check("timeout_idle", 128'({memory_enable, bus_error}), 128'(0));
        next_cycle();

        // Reset in the middle of a data access
        data_request    = 1'b1;
        data_write      = 1'b1;
        data_select     = 4'hf;
        data_address    = 32'h600;
        data_write_data = 32'h12345678;
        next_cycle();
        #1;
        check("rst_pre_enable", 128'(memory_enable), 128'(1));
        reset = 1'b1;
        #1;
        check("rst_async_clear",
              128'({memory_enable, memory_write, memory_select, memory_address, memory_write_data}), 128'(0));
        check("rst_no_ready", 128'({data_ready, bus_error}), 128'(0));
        next_cycle();
        reset = 1'b0;
        #4;
        check("rst_idle_after", 128'({memory_enable, data_ready}), 128'(0));
        next_cycle();
        memory_ready = 1'b1;
        #4;
        check("rst_regrant",
              128'({memory_enable, memory_write, memory_address, data_ready}),
              128'({1'b1, 1'b1, 32'h600, 1'b1}));
        next_cycle();
        idle_inputs();
        next_cycle();

        // Random traffic against the behavioural model
        f_on = 1'b0; d_on = 1'b0; d_write = 1'b0;
        f_addr = 32'h0; d_addr = 32'h0; d_wd = 32'h0; d_sel = 4'h0;
        m_owner = 0; m_cycles = 0; m_passed = 0; m_stuck = 1'b0;
        m_write = 1'b0; m_sel = 4'h0; m_addr = 32'h0; m_wd = 32'h0;
        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            fetch_request    = f_on;
            fetch_address    = f_addr;
            data_request     = d_on;
            data_write       = d_write;
            data_select      = d_sel;
            data_address     = d_addr;
            data_write_data  = d_wd;
            memory_ready     = m_stuck ? 1'b0 : ($urandom_range(0, 2) == 0);
            memory_read_data = $urandom();
            #4;
            done    = (m_owner != 0) && (memory_ready || m_cycles == TMO + 1);
            exp_fr  = done && m_owner == 1;
            exp_dr  = done && m_owner == 2;
            exp_err = done && !memory_ready;
            exp_fd  = (exp_fr && memory_ready) ? memory_read_data : 32'h0;
            exp_dd  = (exp_dr && memory_ready) ? memory_read_data : 32'h0;
            check("rnd_handshake",
                  128'({memory_enable, fetch_ready, data_ready, bus_error, stall_request}),
                  128'({m_owner != 0, exp_fr, exp_dr, exp_err, (f_on && !exp_fr) || (d_on && !exp_dr)}));
            check("rnd_read_data", 128'({fetch_data, data_read_data}), 128'({exp_fd, exp_dd}));
            if (m_owner != 0)
                check("rnd_fields",
                      128'({memory_write, memory_select, memory_address, (m_owner == 2) ? memory_write_data : 32'h0}),
                      128'({m_write, m_sel, m_addr, m_wd}));

            // What the edge at the end of this cycle does
            if (m_owner != 0) begin
                if (done) m_owner = 0;
                else m_cycles++;
            end else if (f_on && (!d_on || m_passed >= LIMIT)) begin
                m_owner = 1; m_cycles = 1; m_passed = 0;
                m_write = 1'b0; m_sel = 4'hf; m_addr = f_addr; m_wd = 32'h0;
                m_stuck = ($urandom_range(0, 7) == 0);
            end else if (d_on) begin
                m_owner = 2; m_cycles = 1;
                if (f_on) m_passed = (m_passed + 1 > LIMIT) ? LIMIT : m_passed + 1;
                m_write = d_write; m_sel = d_sel; m_addr = d_addr; m_wd = d_wd;
                m_stuck = ($urandom_range(0, 7) == 0);
            end

            // Requesters drop or replace on ready, and otherwise may start a new request
            if (exp_fr || !f_on) begin
                f_on   = exp_fr ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
                f_addr = $urandom() & 32'hFFFC;
            end
            if (exp_dr || !d_on) begin
                d_on    = exp_dr ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
                d_write = ($urandom_range(0, 1) == 1);
                d_sel   = 4'($urandom_range(1, 15));
                d_addr  = $urandom() & 32'hFFFC;
                d_wd    = $urandom();
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
